mem_ctrl: RTL and testbench

Sequencer and arbiter for the single byte-wide RAM port shared by instruction fetch (IF) and the MEM stage of the pipeline. Each granted request is split into 1, 2 or 4 byte accesses, issued back-to-back. Read bytes are assembled little-endian, and completion is signalled with a one-cycle ready pulse to the owning requester. MEM has priority over IF. Stalling the pipeline while a request is pending is the requester's responsibility.

---
 rtl/mem_ctrl_if.sv | 29 ++
 rtl/mem_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Bundle for the shared byte-wide RAM port: IF/MEM request lines and the RAM bus.
// The requesters and the RAM drive the master side; mem_ctrl is the slave.
interface mem_ctrl_if #(parameter int RAM_ADDR_W = 17);
  logic                  if_req_i;
  logic [31:0]           if_addr_i;
  logic                  if_ready_o;
  logic [31:0]           if_inst_o;
  logic                  mem_req_i;
  logic                  mem_we_i;
  logic [1:0]            mem_len_i;
  logic [31:0]           mem_addr_i;
  logic [31:0]           mem_wdata_i;
  logic                  mem_ready_o;
  logic [31:0]           mem_rdata_o;
  logic [RAM_ADDR_W-1:0] ram_addr_o;
  logic                  ram_wr_o;
  logic [7:0]            ram_dout_o;
  logic [7:0]            ram_din_i;

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i, ram_din_i,
    input  if_ready_o, if_inst_o, mem_ready_o, mem_rdata_o, ram_addr_o, ram_wr_o, ram_dout_o
  );

  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i, ram_din_i,
    output if_ready_o, if_inst_o, mem_ready_o, mem_rdata_o, ram_addr_o, ram_wr_o, ram_dout_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF/MEM onto one byte-wide RAM port (MEM wins); reads complete n+2 cycles after grant,
// writes n+1. No backpressure: requesters hold their request level and stall until the ready pulse.
module mem_ctrl #(
  parameter int RAM_ADDR_W = 17
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rbuf;
  logic [2:0]  len;
  logic [2:0]  cnt;
  logic        owner_mem;

  logic [31:0] rbuf_nxt;
  logic [31:0] addr_nxt;
  logic [1:0]  bidx;
  logic [2:0]  grant_len;

  // cnt counts addresses issued; the byte arriving now belongs to address cnt-2
  always_comb begin
    bidx     = 2'(cnt - 3'd2);
    rbuf_nxt = rbuf;
    rbuf_nxt[{bidx, 3'b000} +: 8] = bus.ram_din_i;
    addr_nxt = lat_addr + {29'd0, cnt};
    case (bus.mem_len_i)
      2'b00:   grant_len = 3'd1;
      2'b01:   grant_len = 3'd2;
      default: grant_len = 3'd4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      rbuf            <= '0;
      len             <= '0;
      cnt             <= '0;
      owner_mem       <= 1'b0;
      bus.if_ready_o  <= 1'b0;
      bus.if_inst_o   <= '0;
      bus.mem_ready_o <= 1'b0;
      bus.mem_rdata_o <= '0;
      bus.ram_addr_o  <= '0;
      bus.ram_wr_o    <= 1'b0;
      bus.ram_dout_o  <= '0;
    end else begin
      bus.if_ready_o  <= 1'b0;
      bus.mem_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          bus.ram_addr_o <= '0;
          bus.ram_wr_o   <= 1'b0;
          bus.ram_dout_o <= '0;
          // The ready cycle itself is not a sampling slot; a held request is re-granted one cycle later
          if (!bus.if_ready_o && !bus.mem_ready_o) begin
            if (bus.mem_req_i) begin
              owner_mem      <= 1'b1;
              lat_addr       <= bus.mem_addr_i;
              lat_wdata      <= bus.mem_wdata_i;
              len            <= grant_len;
              cnt            <= 3'd1;
              rbuf           <= '0;
              bus.ram_addr_o <= bus.mem_addr_i[RAM_ADDR_W-1:0];
              if (bus.mem_we_i) begin
                state          <= WR;
                bus.ram_wr_o   <= 1'b1;
                bus.ram_dout_o <= bus.mem_wdata_i[7:0];
              end else begin
                state <= RD;
              end
            end else if (bus.if_req_i) begin
              owner_mem      <= 1'b0;
              lat_addr       <= bus.if_addr_i;
              len            <= 3'd4;
              cnt            <= 3'd1;
              rbuf           <= '0;
              bus.ram_addr_o <= bus.if_addr_i[RAM_ADDR_W-1:0];
              state          <= RD;
            end
          end
        end

        RD: begin
          if (!owner_mem && !bus.if_req_i) begin
            state          <= IDLE;
            bus.ram_addr_o <= '0;
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt >= 3'd2) rbuf <= rbuf_nxt;
            if (cnt < len) bus.ram_addr_o <= addr_nxt[RAM_ADDR_W-1:0];
            else           bus.ram_addr_o <= '0;
            if (cnt == len + 3'd1) begin
              state <= IDLE;
              if (owner_mem) begin
                bus.mem_rdata_o <= rbuf_nxt;
                bus.mem_ready_o <= 1'b1;
              end else begin
                bus.if_inst_o  <= rbuf_nxt;
                bus.if_ready_o <= 1'b1;
              end
            end
          end
        end

        WR: begin
          if (cnt == len) begin
            state           <= IDLE;
            bus.ram_wr_o    <= 1'b0;
            bus.ram_addr_o  <= '0;
            bus.ram_dout_o  <= '0;
            bus.mem_ready_o <= 1'b1;
          end else begin
            bus.ram_addr_o <= addr_nxt[RAM_ADDR_W-1:0];
            bus.ram_dout_o <= lat_wdata[{cnt[1:0], 3'b000} +: 8];
            cnt            <= cnt + 3'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte RAM model, a ready-pulse scoreboard and per-cycle RAM bus trace.
module tb_mem_ctrl;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  mem_ctrl_if #(.RAM_ADDR_W(AW)) bus ();
  mem_ctrl #(.RAM_ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  logic [7:0] ram [0:(1<<AW)-1];

  // Registered read: data for the address seen at this edge appears next cycle
  always @(posedge clk) begin
    bus.ram_din_i <= ram[bus.ram_addr_o];
    if (bus.ram_wr_o) ram[bus.ram_addr_o] = bus.ram_dout_o;
  end

  logic [AW-1:0] addr_at [0:4095];
  bit            wr_at   [0:4095];
  logic [7:0]    dout_at [0:4095];

  always @(negedge clk) begin
    if (cyc < 4096) begin
      addr_at[cyc] = bus.ram_addr_o;
      wr_at[cyc]   = bus.ram_wr_o;
      dout_at[cyc] = bus.ram_dout_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          at;
    bit          chk_data;
  } exp_t;

  exp_t sbq[$];

  always @(negedge clk) begin
    if (!rst && (bus.if_ready_o || bus.mem_ready_o)) begin
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ready: if_ready=%0b mem_ready=%0b with nothing expected (cycle %0d)",
                 bus.if_ready_o, bus.mem_ready_o, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ready_port", {30'd0, bus.mem_ready_o, bus.if_ready_o}, e.is_mem ? 32'd2 : 32'd1);
        chk("ready_cycle", cyc, e.at);
        if (e.chk_data) chk(e.is_mem ? "mem_rdata" : "if_inst", e.is_mem ? bus.mem_rdata_o : bus.if_inst_o, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_mem, input logic [31:0] data, input int at, input bit cd);
    exp_t e;
    e.is_mem = is_mem; e.data = data; e.at = at; e.chk_data = cd;
    sbq.push_back(e);
  endtask

  task automatic mem_issue(input bit we, input logic [1:0] len, input logic [31:0] addr, input logic [31:0] wd);
    bus.mem_req_i = 1'b1; bus.mem_we_i = we; bus.mem_len_i = len;
    bus.mem_addr_i = addr; bus.mem_wdata_i = wd;
  endtask

  // Drops each request in its ready cycle so it is not re-granted
  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((bus.mem_req_i || bus.if_req_i) && n < budget) begin
      step();
      n++;
      if (bus.mem_ready_o) bus.mem_req_i = 1'b0;
      if (bus.if_ready_o)  bus.if_req_i = 1'b0;
    end
    if (bus.mem_req_i || bus.if_req_i) begin
      checks++;
      fails++;
      $display("FAIL timeout: requests still pending after %0d cycles", budget);
      bus.mem_req_i = 1'b0;
      bus.if_req_i  = 1'b0;
    end
    step();
  endtask

  function automatic int wr_count(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) n += int'(wr_at[c]);
    return n;
  endfunction

  initial begin
    int t;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_len_i = '0;
    bus.mem_addr_i = '0; bus.mem_wdata_i = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'h10; ram[17'h103] = 8'h00;
    ram[17'h40]  = 8'h34; ram[17'h41]  = 8'h92;
    ram[17'h200] = 8'h11; ram[17'h201] = 8'h22; ram[17'h202] = 8'h33; ram[17'h203] = 8'h44;
    ram[17'h1FFFE] = 8'hEF; ram[17'h1FFFF] = 8'hBE; ram[17'h0] = 8'hAD; ram[17'h1] = 8'hDE;

    #1 rst = 1'b1;
    step(); step();
    chk("rst_if_ready", {31'd0, bus.if_ready_o}, 32'd0);
    chk("rst_mem_ready", {31'd0, bus.mem_ready_o}, 32'd0);
    chk("rst_ram_wr", {31'd0, bus.ram_wr_o}, 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr_o), 32'd0);
    chk("rst_ram_dout", {24'd0, bus.ram_dout_o}, 32'd0);
    chk("rst_if_inst", bus.if_inst_o, 32'd0);
    chk("rst_mem_rdata", bus.mem_rdata_o, 32'd0);
    rst = 1'b0;
    step();

    // Word fetch
    t = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    push(1'b0, 32'h00100513, t + 6, 1'b1);
    run_until_idle(20);
    for (int k = 0; k < 4; k++) chk("fetch_addr", 32'(addr_at[t + 1 + k]), 32'h100 + k);
    chk("fetch_no_write", wr_count(t, t + 6), 0);

    // Byte store
    t = cyc;
    mem_issue(1'b1, 2'b00, 32'h2003, 32'hAABBCC5A);
    push(1'b1, 32'h0, t + 2, 1'b0);
    run_until_idle(20);
    chk("bstore_wr_count", wr_count(t, t + 3), 1);
    chk("bstore_addr", 32'(addr_at[t + 1]), 32'h2003);
    chk("bstore_dout", {24'd0, dout_at[t + 1]}, 32'h5A);
    chk("bstore_ram", {24'd0, ram[17'h2003]}, 32'h5A);
    chk("bstore_ram_next", {24'd0, ram[17'h2004]}, 32'h00);

    // Simultaneous requests: MEM half load first, then fetch
    t = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    mem_issue(1'b0, 2'b01, 32'h40, 32'h0);
    push(1'b1, 32'h00009234, t + 4, 1'b1);
    push(1'b0, 32'h00100513, t + 11, 1'b1);
    run_until_idle(40);
    chk("simul_if_addr", 32'(addr_at[t + 6]), 32'h100);

    // IF abort in the second RD cycle with a pending byte load
    t = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
    step();
    step();
    bus.if_req_i = 1'b0;
    mem_issue(1'b0, 2'b00, 32'h40, 32'h0);
    push(1'b1, 32'h00000034, t + 6, 1'b1);
    run_until_idle(20);
    chk("abort_idle_addr", 32'(addr_at[t + 3]), 32'h0);
    chk("abort_mem_addr", 32'(addr_at[t + 4]), 32'h40);
    chk("abort_if_inst_kept", bus.if_inst_o, 32'h00100513);

    // Asynchronous reset during the third byte of a word store
    t = cyc;
    mem_issue(1'b1, 2'b10, 32'h3000, 32'h44332211);
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ram_wr", {31'd0, bus.ram_wr_o}, 32'd0);
    chk("mid_rst_ram_addr", 32'(bus.ram_addr_o), 32'd0);
    chk("mid_rst_ram_dout", {24'd0, bus.ram_dout_o}, 32'd0);
    chk("mid_rst_if_inst", bus.if_inst_o, 32'd0);
    chk("mid_rst_mem_rdata", bus.mem_rdata_o, 32'd0);
    bus.mem_req_i = 1'b0;
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    chk("mid_rst_b0", {24'd0, ram[17'h3000]}, 32'h11);
    chk("mid_rst_b1", {24'd0, ram[17'h3001]}, 32'h22);
    chk("mid_rst_b2", {24'd0, ram[17'h3002]}, 32'h00);
    chk("mid_rst_b3", {24'd0, ram[17'h3003]}, 32'h00);
    t = cyc;
    mem_issue(1'b0, 2'b00, 32'h3001, 32'h0);
    push(1'b1, 32'h00000022, t + 3, 1'b1);
    run_until_idle(20);

    // Address wrap on a word load
    t = cyc;
    mem_issue(1'b0, 2'b10, 32'hFFFFFFFE, 32'h0);
    push(1'b1, 32'hDEADBEEF, t + 6, 1'b1);
    run_until_idle(20);
    chk("wrap_a0", 32'(addr_at[t + 1]), 32'h1FFFE);
    chk("wrap_a1", 32'(addr_at[t + 2]), 32'h1FFFF);
    chk("wrap_a2", 32'(addr_at[t + 3]), 32'h0);
    chk("wrap_a3", 32'(addr_at[t + 4]), 32'h1);

    // Word store, unaligned half load, and len=11 word load
    t = cyc;
    mem_issue(1'b1, 2'b10, 32'h500, 32'hCAFEF00D);
    push(1'b1, 32'h0, t + 5, 1'b0);
    run_until_idle(20);
    chk("wstore_wr_count", wr_count(t, t + 6), 4);
    chk("wstore_ram", {ram[17'h503], ram[17'h502], ram[17'h501], ram[17'h500]}, 32'hCAFEF00D);
    t = cyc;
    mem_issue(1'b0, 2'b01, 32'h501, 32'h0);
    push(1'b1, 32'h0000FEF0, t + 4, 1'b1);
    run_until_idle(20);
    t = cyc;
    mem_issue(1'b0, 2'b11, 32'h500, 32'h0);
    push(1'b1, 32'hCAFEF00D, t + 6, 1'b1);
    run_until_idle(20);

    step(); step();
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
